// File: rtl/cb_pkg.sv
// Shared definitions for the parametrised vertical connection block:
// width helpers, the ipin-to-track wiring rule and the load-state type.
package cb_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Select bits needed per ipin mux.
  function automatic int sel_width(input int mux_size);
    return (mux_size < 2) ? 1 : clog2(mux_size);
  endfunction

  // Configuration chain length for the whole block.
  function automatic int chain_len(input int num_ipin, input int mux_size);
    return num_ipin * sel_width(mux_size);
  endfunction

  // Width of a counter that must reach the full chain length.
  function automatic int count_width(input int total);
    return (total < 1) ? 1 : clog2(total + 1);
  endfunction

  // Track feeding input k of the mux on ipin i. Pins are spread across
  // the channel with a stride so neighbouring pins see different tracks;
  // each pair of mux inputs (bottom/top) shares one track index.
  function automatic int track_of(input int i, input int k,
                                  input int chan_w, input int mux_size);
    int stride;
    stride = chan_w / (mux_size / 2);
    return (i % stride) + (k / 2) * stride;
  endfunction

  // Load progress of the shadow register, derived from the shift count.
  typedef enum logic [1:0] {
    LOAD_EMPTY   = 2'd0,
    LOAD_LOADING = 2'd1,
    LOAD_FULL    = 2'd2
  } load_state_e;

endpackage

// File: rtl/cb_cfg_chain.sv
// Double-buffered configuration chain: a serial shadow register that is
// copied into the active register on an accepted commit, plus the shift
// counter and the valid/error flags that describe load progress.
//
// Handshake: cfg_en qualifies one shift per prog_clk edge; cfg_commit is a
// one-edge pulse that is accepted only when the shadow is full (count at
// TOTAL). A rejected commit leaves active untouched and sets the sticky
// error flag. Commit and shift may coincide: active takes the pre-edge
// shadow while the shift still happens.
module cb_cfg_chain
  import cb_pkg::*;
#(
  parameter int TOTAL = 22,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              ccff_head,
  input  logic              cfg_commit,
  output logic [TOTAL-1:0]  active,
  output logic              ccff_tail,
  output logic [CNT_W-1:0]  cfg_count,
  output logic              cfg_valid,
  output logic              cfg_err,
  output load_state_e       load_state
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [TOTAL-1:0] shadow;
  logic [TOTAL:0]   shift_vec;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             commit_ok;

  // New bit enters at bit 0; the oldest bit falls off the top.
  assign shift_vec = {shadow, ccff_head};
  assign full      = (cfg_count == FULL_CNT);
  assign commit_ok = cfg_commit & full;
  assign ccff_tail = shadow[TOTAL-1];

  // Shadow shift register, active copy and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_en) begin
        shadow <= shift_vec[TOTAL-1:0];
      end
      if (commit_ok) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
      end
      if (cfg_commit && !full) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Shift counter register (the load-state machine's state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_count <= '0;
    end else begin
      cfg_count <= count_next;
    end
  end

  // Next count: restart on an accepted commit, else saturating increment.
  always_comb begin
    count_next = cfg_count;
    if (commit_ok) begin
      count_next = cfg_en ? ONE_CNT : '0;
    end else if (cfg_en && !full) begin
      count_next = cfg_count + ONE_CNT;
    end
  end

  // Load state decoded from the count for status and debug.
  always_comb begin
    load_state = LOAD_LOADING;
    if (cfg_count == '0) begin
      load_state = LOAD_EMPTY;
    end else if (full) begin
      load_state = LOAD_FULL;
    end
  end

endmodule

// File: rtl/cby_param_cb.sv
// Parametrised vertical connection block. Tracks pass straight through in
// both directions; each grid input pin is driven by a MUX_SIZE:1 track mux
// whose select comes from the committed (active) configuration.
module cby_param_cb
  import cb_pkg::*;
#(
  parameter  int CHAN_W   = 10,
  parameter  int NUM_IPIN = 11,
  parameter  int MUX_SIZE = 4,
  localparam int SEL_W    = sel_width(MUX_SIZE),
  localparam int TOTAL    = chain_len(NUM_IPIN, MUX_SIZE),
  localparam int CNT_W    = count_width(TOTAL)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                cfg_en,
  input  logic                ccff_head,
  input  logic                cfg_commit,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic [CNT_W-1:0]    cfg_count,
  output logic                cfg_done,
  output logic                cfg_valid,
  output logic                cfg_err
);

  // Mux input vector is padded to a power of two so every select value
  // indexes a real bit; padded inputs read as 0.
  localparam int MUX_W = 1 << SEL_W;

  logic [TOTAL-1:0] active;
  load_state_e      chain_state;

  // Pass-through is purely combinational and independent of configuration.
  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  cb_cfg_chain #(
    .TOTAL (TOTAL),
    .CNT_W (CNT_W)
  ) u_chain (
    .clk        (prog_clk),
    .rst        (pReset),
    .cfg_en     (cfg_en),
    .ccff_head  (ccff_head),
    .cfg_commit (cfg_commit),
    .active     (active),
    .ccff_tail  (ccff_tail),
    .cfg_count  (cfg_count),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .load_state (chain_state)
  );

  assign cfg_done = (chain_state == LOAD_FULL);

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    logic [MUX_W-1:0] mux_in;
    logic [SEL_W-1:0] sel;

    for (genvar k = 0; k < MUX_W; k++) begin : g_in
      if (k >= MUX_SIZE) begin : g_pad
        assign mux_in[k] = 1'b0;
      end else if ((k % 2) == 0) begin : g_bot
        assign mux_in[k] = chany_bottom_in[track_of(i, k, CHAN_W, MUX_SIZE)];
      end else begin : g_top
        assign mux_in[k] = chany_top_in[track_of(i, k, CHAN_W, MUX_SIZE)];
      end
    end

    assign sel = active[i*SEL_W +: SEL_W];
    // Gate with cfg_valid so an uncommitted block never drives a pin.
    assign ipin_out[i] = cfg_valid & mux_in[sel];
  end

endmodule

// File: tb/tb_cby_param_cb.sv
// Self-checking bench for cby_param_cb: hand sequences for reset, wiring,
// early commit, chain latency and mid-load reset, a table of input vectors
// for a fixed configuration, and randomized loads against a reference model.
module tb_cby_param_cb;

  localparam int CHAN_W   = 10;
  localparam int NUM_IPIN = 11;
  localparam int MUX_SIZE = 4;
  localparam int SEL_W    = 2;
  localparam int TOTAL    = 22;
  localparam int CNT_W    = 5;
  localparam int S        = 5;

  logic                prog_clk;
  logic                pReset;
  logic                cfg_en;
  logic                ccff_head;
  logic                cfg_commit;
  logic [CHAN_W-1:0]   chany_bottom_in;
  logic [CHAN_W-1:0]   chany_top_in;
  logic [CHAN_W-1:0]   chany_bottom_out;
  logic [CHAN_W-1:0]   chany_top_out;
  logic [NUM_IPIN-1:0] ipin_out;
  logic                ccff_tail;
  logic [CNT_W-1:0]    cfg_count;
  logic                cfg_done;
  logic                cfg_valid;
  logic                cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  cby_param_cb #(
    .CHAN_W   (CHAN_W),
    .NUM_IPIN (NUM_IPIN),
    .MUX_SIZE (MUX_SIZE)
  ) dut (
    .prog_clk         (prog_clk),
    .pReset           (pReset),
    .cfg_en           (cfg_en),
    .ccff_head        (ccff_head),
    .cfg_commit       (cfg_commit),
    .chany_bottom_in  (chany_bottom_in),
    .chany_top_in     (chany_top_in),
    .chany_bottom_out (chany_bottom_out),
    .chany_top_out    (chany_top_out),
    .ipin_out         (ipin_out),
    .ccff_tail        (ccff_tail),
    .cfg_count        (cfg_count),
    .cfg_done         (cfg_done),
    .cfg_valid        (cfg_valid),
    .cfg_err          (cfg_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Shadow kept as a history of shifted bits, newest at index 0.
  bit m_shadow[$];
  int m_sel[NUM_IPIN];     // committed select per ipin
  int m_count;
  bit m_valid;
  bit m_err;

  function automatic void model_reset();
    m_shadow = {};
    for (int j = 0; j < TOTAL; j++) m_shadow.push_back(1'b0);
    for (int i = 0; i < NUM_IPIN; i++) m_sel[i] = 0;
    m_count = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_edge(input bit en, input bit head, input bit commit);
    bit done;
    done = (m_count == TOTAL);
    if (commit) begin
      if (done) begin
        for (int i = 0; i < NUM_IPIN; i++)
          m_sel[i] = m_shadow[i*SEL_W] + 2 * m_shadow[i*SEL_W+1];
        m_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (en) begin
      m_shadow.push_front(head);
      void'(m_shadow.pop_back());
    end
    if (commit && done) m_count = en ? 1 : 0;
    else if (en && m_count < TOTAL) m_count = m_count + 1;
  endfunction

  // Expected pins from the wiring rule applied to the current track inputs.
  function automatic logic [NUM_IPIN-1:0] model_ipin();
    logic [NUM_IPIN-1:0] r;
    int t;
    r = '0;
    for (int i = 0; i < NUM_IPIN; i++) begin
      if (m_valid && m_sel[i] < MUX_SIZE) begin
        t = (i % S) + (m_sel[i] / 2) * S;
        r[i] = (m_sel[i] % 2 == 0) ? chany_bottom_in[t] : chany_top_in[t];
      end
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " cfg_count"}, 32'(cfg_count), 32'(m_count));
    check({tag, " cfg_done"},  32'(cfg_done),  32'(m_count == TOTAL));
    check({tag, " cfg_valid"}, 32'(cfg_valid), 32'(m_valid));
    check({tag, " cfg_err"},   32'(cfg_err),   32'(m_err));
    check({tag, " ccff_tail"}, 32'(ccff_tail), 32'(m_shadow[TOTAL-1]));
    check({tag, " ipin_out"},  32'(ipin_out),  32'(model_ipin()));
    check({tag, " top_out"},   32'(chany_top_out),    32'(chany_bottom_in));
    check({tag, " bottom_out"},32'(chany_bottom_out), 32'(chany_top_in));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; applies one rising edge.
  task automatic step(input bit en, input bit head, input bit commit);
    cfg_en     = en;
    ccff_head  = head;
    cfg_commit = commit;
    @(posedge prog_clk);
    model_edge(en, head, commit);
    @(negedge prog_clk);
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    pReset = 1'b1;
    #2;
    model_reset();
    pReset = 1'b0;
    @(negedge prog_clk);
  endtask

  // Shift a full configuration; first bit ends at the top of the shadow.
  task automatic load_config(input int sel[NUM_IPIN], input bit rand_tracks, input string tag);
    bit b;
    for (int j = TOTAL - 1; j >= 0; j--) begin
      b = 1'((sel[j / SEL_W] >> (j % SEL_W)) & 1);
      if (rand_tracks) begin
        chany_bottom_in = CHAN_W'($urandom);
        chany_top_in    = CHAN_W'($urandom);
      end
      step(1'b1, b, 1'b0);
      check_all(tag);
    end
  endtask

  typedef struct {
    logic [CHAN_W-1:0]   bottom;
    logic [CHAN_W-1:0]   top;
    logic [NUM_IPIN-1:0] exp;
  } vec_t;

  vec_t tbl[7];
  int   sel_cfg[NUM_IPIN];

  initial begin
    // Config ipin0 sel=2 (bottom[5]), others sel=0 (bottom[i mod 5]).
    tbl[0] = '{bottom: 10'h000, top: 10'h3FF, exp: 11'h000};
    tbl[1] = '{bottom: 10'h020, top: 10'h000, exp: 11'h001};
    tbl[2] = '{bottom: 10'h001, top: 10'h000, exp: 11'h420};
    tbl[3] = '{bottom: 10'h01E, top: 10'h3FF, exp: 11'h3DE};
    tbl[4] = '{bottom: 10'h3FF, top: 10'h000, exp: 11'h7FF};
    tbl[5] = '{bottom: 10'h3E0, top: 10'h3FF, exp: 11'h001};
    tbl[6] = '{bottom: 10'h021, top: 10'h155, exp: 11'h421};

    pReset = 1'b1; cfg_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
    chany_bottom_in = '0; chany_top_in = '0;
    model_reset();

    // Reset state.
    do_reset();
    check_all("reset");
    check("reset ipin_out", 32'(ipin_out), 32'h0);
    check("reset ccff_tail", 32'(ccff_tail), 32'h0);

    // Pass-through during a shift, before the edge.
    chany_top_in = 10'h2A5; chany_bottom_in = 10'h155; cfg_en = 1'b1;
    #1;
    check("pass bottom_out", 32'(chany_bottom_out), 32'h2A5);
    check("pass top_out", 32'(chany_top_out), 32'h155);
    step(1'b1, 1'b0, 1'b0);
    check_all("pass");

    // Configure ipin0 sel=2, others 0, then table of track vectors.
    do_reset();
    foreach (sel_cfg[i]) sel_cfg[i] = 0;
    sel_cfg[0] = 2;
    load_config(sel_cfg, 1'b0, "cfg0");
    check("cfg0 done", 32'(cfg_done), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check_all("cfg0 commit");
    check("cfg0 valid", 32'(cfg_valid), 32'h1);
    check("cfg0 count", 32'(cfg_count), 32'h0);
    for (int v = 0; v < 7; v++) begin
      chany_bottom_in = tbl[v].bottom;
      chany_top_in    = tbl[v].top;
      #1;
      check($sformatf("tbl%0d ipin_out", v), 32'(ipin_out), 32'(tbl[v].exp));
      check($sformatf("tbl%0d bottom_out", v), 32'(chany_bottom_out), 32'(tbl[v].top));
    end
    @(negedge prog_clk);

    // Early commit at count 10: error set, nothing else moves.
    chany_bottom_in = 10'h3FF; chany_top_in = 10'h000;
    for (int n = 0; n < 10; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_all("early");
    check("early cfg_err", 32'(cfg_err), 32'h1);
    check("early cfg_count", 32'(cfg_count), 32'd10);
    check("early ipin_out", 32'(ipin_out), 32'h7FF);

    // Chain latency: a single 1 followed by zeros.
    do_reset();
    for (int n = 1; n <= 23; n++) begin
      step(1'b1, (n == 1), 1'b0);
      check($sformatf("lat%0d ccff_tail", n), 32'(ccff_tail), 32'(n == 22));
      check_all("lat");
    end
    check("lat sat count", 32'(cfg_count), 32'd22);
    check("lat done", 32'(cfg_done), 32'h1);

    // Commit and shift on the same edge.
    step(1'b1, 1'b1, 1'b1);
    check_all("commit+shift");
    check("commit+shift count", 32'(cfg_count), 32'd1);

    // Mid-load reset after a valid commit.
    do_reset();
    foreach (sel_cfg[i]) sel_cfg[i] = $urandom_range(0, 3);
    load_config(sel_cfg, 1'b1, "mid load");
    step(1'b0, 1'b0, 1'b1);
    chany_bottom_in = 10'h3FF; chany_top_in = 10'h3FF;
    for (int n = 0; n < 12; n++) step(1'b1, 1'b1, 1'b0);
    check_all("mid pre");
    check("mid pre ipin_out", 32'(ipin_out), 32'h7FF);
    #2;
    pReset = 1'b1;
    #1;
    check("mid rst ipin_out", 32'(ipin_out), 32'h0);
    check("mid rst cfg_valid", 32'(cfg_valid), 32'h0);
    check("mid rst cfg_count", 32'(cfg_count), 32'h0);
    model_reset();
    #1;
    pReset = 1'b0;
    @(negedge prog_clk);
    check_all("mid post");
    // Shadow cleared: zeros shifted in leave only zeros at the tail.
    for (int n = 0; n < TOTAL; n++) begin
      step(1'b1, 1'b0, 1'b0);
      check_all("mid shadow");
    end
    step(1'b0, 1'b0, 1'b1);
    check_all("mid zero cfg");

    // Randomized loads, commits and track traffic.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      foreach (sel_cfg[i]) sel_cfg[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int n = 0; n < int'($urandom_range(1, 5)); n++)
          step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_all("rnd early");
      end
      load_config(sel_cfg, 1'b1, "rnd load");
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      check_all("rnd commit");
      for (int v = 0; v < 6; v++) begin
        chany_bottom_in = CHAN_W'($urandom);
        chany_top_in    = CHAN_W'($urandom);
        #1;
        check_all("rnd vec");
      end
      @(negedge prog_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
